// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction/data memory handshake bundle for mc_controller
interface mc_controller_if;
   logic       imem_req;
   logic       instr_ready;
   logic       dmem_req;
   logic       mem_ready;
   logic       mem_write;
   logic [3:0] byte_en;

   modport master (
      output imem_req, dmem_req, mem_write, byte_en,
      input  instr_ready, mem_ready
   );

   modport slave (
      input  imem_req, dmem_req, mem_write, byte_en,
      output instr_ready, mem_ready
   );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB)
module mc_controller #(
   parameter int ALUOP_W    = 3,
   parameter bit SUPPORT_SB = 1'b1,
   parameter int CNT_W      = 32
) (
   input  logic               clk,
   input  logic               reset,
   mc_controller_if.master    mem,
   input  logic [5:0]         op,
   input  logic [5:0]         func,
   input  logic               zero,
   input  logic [1:0]         addr_lo,
   output logic               ir_we,
   output logic               pc_we,
   output logic [1:0]         pc_src,
   output logic               reg_write,
   output logic [1:0]         reg_dst,
   output logic [1:0]         wd_sel,
   output logic               alu_src,
   output logic               ext_sign,
   output logic [ALUOP_W-1:0] alu_ctrl,
   output logic               illegal,
   output logic               retire,
   output logic [CNT_W-1:0]   retire_cnt
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_NOP  = 6'b000000;

   state_t     state;
   logic [5:0] op_q;
   logic [5:0] func_q;

   logic is_r, is_addu, is_subu, is_or, is_jr, is_nop;
   logic is_ori, is_lui, is_lw, is_sw, is_sb, is_beq, is_j, is_jal;
   logic is_store, is_mem, legal, misalign;
   logic [2:0] alu_code;

   assign is_r     = (op_q == OP_R);
   assign is_addu  = is_r && (func_q == F_ADDU);
   assign is_subu  = is_r && (func_q == F_SUBU);
   assign is_or    = is_r && (func_q == F_OR);
   assign is_jr    = is_r && (func_q == F_JR);
   assign is_nop   = is_r && (func_q == F_NOP);
   assign is_ori   = (op_q == OP_ORI);
   assign is_lui   = (op_q == OP_LUI);
   assign is_lw    = (op_q == OP_LW);
   assign is_sw    = (op_q == OP_SW);
   assign is_sb    = (op_q == OP_SB) && SUPPORT_SB;
   assign is_beq   = (op_q == OP_BEQ);
   assign is_j     = (op_q == OP_J);
   assign is_jal   = (op_q == OP_JAL);
   assign is_store = is_sw || is_sb;
   assign is_mem   = is_lw || is_store;
   assign legal    = is_addu || is_subu || is_or || is_jr || is_nop || is_ori || is_lui
                  || is_mem || is_beq || is_j || is_jal;
   // sb may hit any byte lane; only word accesses need alignment
   assign misalign = (is_lw || is_sw) && (addr_lo != 2'b00);

   always_comb begin
      alu_code = 3'd0;
      if (is_subu || is_beq)    alu_code = 3'd1;
      else if (is_ori || is_or) alu_code = 3'd3;
      else if (is_lui)          alu_code = 3'd4;
   end

   always_comb begin
      mem.imem_req  = 1'b0;
      mem.dmem_req  = 1'b0;
      mem.mem_write = 1'b0;
      mem.byte_en   = 4'b0000;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_src        = 2'd0;
      reg_write     = 1'b0;
      reg_dst       = 2'd0;
      wd_sel        = 2'd0;
      alu_src       = 1'b0;
      ext_sign      = 1'b0;
      alu_ctrl      = '0;
      retire        = 1'b0;
      // gating on reset makes every enable drop the instant reset asserts
      if (reset) begin
         if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            alu_src  = is_ori || is_lui || is_mem;
            ext_sign = is_mem || is_beq;
            alu_ctrl = ALUOP_W'(alu_code);
         end
         case (state)
            S_FETCH: begin
               mem.imem_req = 1'b1;
               if (mem.instr_ready) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            S_DECODE: begin
               if (is_nop) begin
                  retire = 1'b1;
               end else if (is_j || is_jal) begin
                  pc_we  = 1'b1;
                  pc_src = 2'd2;
                  retire = 1'b1;
                  if (is_jal) begin
                     reg_write = 1'b1;
                     reg_dst   = 2'd2;
                     wd_sel    = 2'd2;
                  end
               end else if (is_jr) begin
                  pc_we  = 1'b1;
                  pc_src = 2'd3;
                  retire = 1'b1;
               end
            end
            S_EXEC: begin
               if (is_beq) begin
                  pc_we  = zero;
                  pc_src = 2'd1;
                  retire = 1'b1;
               end
            end
            S_MEM: begin
               mem.dmem_req  = 1'b1;
               mem.mem_write = is_store;
               mem.byte_en   = is_sb ? (4'b0001 << addr_lo) : 4'b1111;
               retire        = is_store && mem.mem_ready;
            end
            S_WB: begin
               reg_write = 1'b1;
               reg_dst   = is_r ? 2'd1 : 2'd0;
               wd_sel    = is_lw ? 2'd1 : 2'd0;
               retire    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_FETCH;
         op_q       <= 6'd0;
         func_q     <= 6'd0;
         illegal    <= 1'b0;
         retire_cnt <= '0;
      end else begin
         if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
         case (state)
            S_FETCH: begin
               if (mem.instr_ready) begin
                  op_q   <= op;
                  func_q <= func;
                  state  <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!legal) begin
                  illegal <= 1'b1;
                  state   <= S_FETCH;
               end else if (is_nop || is_j || is_jal || is_jr) begin
                  state <= S_FETCH;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_beq) begin
                  state <= S_FETCH;
               end else if (is_mem) begin
                  if (misalign) begin
                     illegal <= 1'b1;
                     state   <= S_FETCH;
                  end else begin
                     state <= S_MEM;
                  end
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (mem.mem_ready) state <= is_lw ? S_WB : S_FETCH;
            end
            S_WB:    state <= S_FETCH;
            default: state <= S_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;
   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_JAL = 6'b000011;
   localparam logic [5:0] F_ADDU = 6'b100001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, reset_b;
   logic [5:0] op, func;
   logic       zero;
   logic [1:0] addr_lo;
   logic       ir, mr;

   mc_controller_if ifa();
   mc_controller_if ifb();
   assign ifa.instr_ready = ir;
   assign ifa.mem_ready   = mr;
   assign ifb.instr_ready = ir;
   assign ifb.mem_ready   = mr;

   logic        ir_we_a, pc_we_a, reg_write_a, alu_src_a, ext_sign_a, illegal_a, retire_a;
   logic [1:0]  pc_src_a, reg_dst_a, wd_sel_a;
   logic [2:0]  alu_ctrl_a;
   logic [31:0] retire_cnt_a;
   logic        ir_we_b, pc_we_b, reg_write_b, alu_src_b, ext_sign_b, illegal_b, retire_b;
   logic [1:0]  pc_src_b, reg_dst_b, wd_sel_b;
   logic [2:0]  alu_ctrl_b;
   logic [3:0]  retire_cnt_b;

   mc_controller #(.ALUOP_W(3), .SUPPORT_SB(1'b1), .CNT_W(32)) dut_a (
      .clk(clk), .reset(reset_a), .mem(ifa.master),
      .op(op), .func(func), .zero(zero), .addr_lo(addr_lo),
      .ir_we(ir_we_a), .pc_we(pc_we_a), .pc_src(pc_src_a), .reg_write(reg_write_a),
      .reg_dst(reg_dst_a), .wd_sel(wd_sel_a), .alu_src(alu_src_a), .ext_sign(ext_sign_a),
      .alu_ctrl(alu_ctrl_a), .illegal(illegal_a), .retire(retire_a), .retire_cnt(retire_cnt_a)
   );

   mc_controller #(.ALUOP_W(3), .SUPPORT_SB(1'b0), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset_b), .mem(ifb.master),
      .op(op), .func(func), .zero(zero), .addr_lo(addr_lo),
      .ir_we(ir_we_b), .pc_we(pc_we_b), .pc_src(pc_src_b), .reg_write(reg_write_b),
      .reg_dst(reg_dst_b), .wd_sel(wd_sel_b), .alu_src(alu_src_b), .ext_sign(ext_sign_b),
      .alu_ctrl(alu_ctrl_b), .illegal(illegal_b), .retire(retire_b), .retire_cnt(retire_cnt_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int         n_cyc, n_dreq, n_ret;
   logic       irwe0, pcwe0, pcwe_late, rw, mw, bad_be;
   logic [1:0] rd, wd, pcsrc_r;
   logic [3:0] be;
   logic [2:0] alu;

   // Runs one instruction on dut_a from its FETCH cycle until FETCH comes back.
   task automatic run(input logic [5:0] o, input logic [5:0] f, input logic [1:0] al,
                      input logic z, input int mwait);
      int   k;
      logic done;
      k = 0; done = 1'b0;
      op = o; func = f; addr_lo = al; zero = z; ir = 1'b1; mr = 1'b0;
      n_cyc = 0; n_dreq = 0; n_ret = 0;
      irwe0 = 0; pcwe0 = 0; pcwe_late = 0; rw = 0; mw = 0; bad_be = 0;
      rd = 0; wd = 0; pcsrc_r = 0; be = 0; alu = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         mr = 1'b0;
         #1;
         if (c > 0 && ifa.imem_req) begin
            done = 1'b1;
         end else begin
            if (ifa.dmem_req) begin
               mr = (k >= mwait);
               k++;
               #1;
               n_dreq++;
               be = be | ifa.byte_en;
               mw = mw | ifa.mem_write;
            end else if (ifa.byte_en != 4'b0000) begin
               bad_be = 1'b1;
            end
            if (c == 0) begin
               irwe0 = ir_we_a;
               pcwe0 = pc_we_a;
            end else if (pc_we_a) begin
               pcwe_late = 1'b1;
            end
            if (reg_write_a) begin
               rw = 1'b1; rd = reg_dst_a; wd = wd_sel_a; alu = alu_ctrl_a;
            end
            if (retire_a) begin
               n_ret++;
               pcsrc_r = pc_src_a;
            end
            n_cyc++;
            @(posedge clk); #1;
         end
      end
      chk("run_done", done, 1);
      chk("be_idle", bad_be, 0);
   endtask

   logic any_dreq;

   initial begin
      reset_a = 0; reset_b = 0;
      op = 0; func = 0; zero = 0; addr_lo = 0; ir = 0; mr = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_imem", ifa.imem_req, 0);
      chk("rst_cnt", retire_cnt_a, 0);
      chk("rst_ill", illegal_a, 0);
      reset_a = 1;
      #1;
      chk("fetch_imem", ifa.imem_req, 1);
      chk("fetch_irwe_wait", ir_we_a, 0);

      run(OP_R, F_ADDU, 2'd0, 1'b0, 0);
      chk("addu_irwe", irwe0, 1);
      chk("addu_pcwe", pcwe0, 1);
      chk("addu_cyc", n_cyc, 4);
      chk("addu_rw", rw, 1);
      chk("addu_rd", rd, 1);
      chk("addu_alu", alu, 0);
      chk("addu_cnt", retire_cnt_a, 1);

      // reset while lw sits in MEM
      op = OP_LW; func = 0; addr_lo = 0; ir = 1; mr = 0;
      repeat (3) begin @(posedge clk); #1; end
      chk("mem_dreq", ifa.dmem_req, 1);
      reset_a = 0;
      #1;
      chk("rstmem_dreq", ifa.dmem_req, 0);
      chk("rstmem_imem", ifa.imem_req, 0);
      chk("rstmem_be", ifa.byte_en, 0);
      @(posedge clk); #1;
      reset_a = 1;
      #1;
      chk("rel_fetch", ifa.imem_req, 1);
      chk("rel_cnt", retire_cnt_a, 0);
      chk("rel_ill", illegal_a, 0);

      run(OP_LW, 6'd0, 2'd0, 1'b0, 3);
      chk("lw_cyc", n_cyc, 8);
      chk("lw_dreq", n_dreq, 4);
      chk("lw_be", be, 4'b1111);
      chk("lw_mw", mw, 0);
      chk("lw_wd", wd, 1);
      chk("lw_rd", rd, 0);
      chk("lw_cnt", retire_cnt_a, 1);

      run(OP_SB, 6'd0, 2'd3, 1'b0, 0);
      chk("sb_cyc", n_cyc, 4);
      chk("sb_be", be, 4'b1000);
      chk("sb_mw", mw, 1);
      chk("sb_rw", rw, 0);
      chk("sb_cnt", retire_cnt_a, 2);

      run(OP_BEQ, 6'd0, 2'd0, 1'b1, 0);
      chk("beq1_cyc", n_cyc, 3);
      chk("beq1_pcwe", pcwe_late, 1);
      chk("beq1_src", pcsrc_r, 1);
      run(OP_BEQ, 6'd0, 2'd0, 1'b0, 0);
      chk("beq0_cyc", n_cyc, 3);
      chk("beq0_pcwe", pcwe_late, 0);
      chk("beq_cnt", retire_cnt_a, 4);

      run(OP_JAL, 6'd0, 2'd0, 1'b0, 0);
      chk("jal_cyc", n_cyc, 2);
      chk("jal_rw", rw, 1);
      chk("jal_rd", rd, 2);
      chk("jal_wd", wd, 2);
      chk("jal_src", pcsrc_r, 2);

      run(OP_ORI, 6'd0, 2'd0, 1'b0, 0);
      chk("ori_cyc", n_cyc, 4);
      chk("ori_alu", alu, 3);
      chk("ori_rd", rd, 0);
      chk("ori_cnt", retire_cnt_a, 6);

      run(OP_SW, 6'd0, 2'd2, 1'b0, 0);
      chk("swmis_cyc", n_cyc, 3);
      chk("swmis_dreq", n_dreq, 0);
      chk("swmis_ret", n_ret, 0);
      chk("swmis_ill", illegal_a, 1);
      chk("swmis_cnt", retire_cnt_a, 6);

      // narrow counter and no-sb variant
      reset_a = 0;
      op = OP_R; func = 6'd0; addr_lo = 0; ir = 1; mr = 0;
      @(posedge clk); #1;
      reset_b = 1;
      repeat (32) begin @(posedge clk); #1; end
      chk("nop16_cnt", retire_cnt_b, 0);
      repeat (2) begin @(posedge clk); #1; end
      chk("nop17_cnt", retire_cnt_b, 1);
      chk("nop17_fetch", ifb.imem_req, 1);

      op = OP_SB; addr_lo = 2'd3; any_dreq = 0;
      repeat (4) begin
         #1;
         any_dreq = any_dreq | ifb.dmem_req;
         @(posedge clk); #1;
      end
      chk("nosb_ill", illegal_b, 1);
      chk("nosb_dreq", any_dreq, 0);
      chk("nosb_cnt", retire_cnt_b, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready handshakes on instruction and data memory.
- Drives datapath enables and muxes, generates byte enables for sb, flags illegal or misaligned instructions, and counts retired instructions.
- Sits between the IR/PC/regfile/ALU datapath and the two memory ports.

Parameters:
- ALUOP_W, 3, width of alu_ctrl (must be >=3; upper bits zero).
- SUPPORT_SB, 1, when 1 sb (op 101000) is legal; when 0 it is illegal.
- CNT_W, 32, width of retire_cnt.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26] from memory data, captured when ir_we=1.
- func  in  6  IR[5:0], captured with op.
- zero  in  1  ALU zero flag.
- addr_lo  in  2  ALU result [1:0] (data address low bits).
- instr_ready  in  1  imem has valid instruction this cycle.
- mem_ready  in  1  dmem completes access this cycle.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  IR load.
- pc_we  out  1  PC load.
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs (jr).
- dmem_req  out  1  data access request.
- mem_write  out  1  store when dmem_req.
- byte_en  out  4  store/load byte lanes.
- reg_write  out  1  regfile write.
- reg_dst  out  2  0 rt, 1 rd, 2 $31.
- wd_sel  out  2  0 ALU, 1 mem data, 2 PC register (already PC+4).
- alu_src  out  1  1 selects immediate.
- ext_sign  out  1  1 sign-extend immediate, 0 zero-extend.
- alu_ctrl  out  ALUOP_W  0 add, 1 sub, 3 or, 4 lui.
- illegal  out  1  sticky error flag.
- retire  out  1  one-cycle pulse on final cycle of each instruction.
- retire_cnt  out  CNT_W  retired instruction count, wraps at 2^CNT_W.

Behaviour:
- Reset (async, reset=0): state=FETCH, captured op/func=0, illegal=0, retire_cnt=0.
- All outputs are combinational from state and captured op/func; every enable is 0 while reset is low.
- Reset mid-access drops imem_req/dmem_req immediately.
- Legal set:
  - R-type (op 000000): addu (func 100001), subu (100011), or (100101), jr (001000), nop (000000).
  - I/J-type op codes: ori 001101, lui 001111, lw 100011, sw 101011, sb 101000 (if SUPPORT_SB), beq 000100, j 000010, jal 000011.
  - Anything else is illegal.
- FETCH: imem_req=1 and hold until instr_ready.
  - On the cycle instr_ready=1: ir_we=1, pc_we=1, pc_src=0, capture op/func, go to DECODE.
- DECODE:
  - nop: retire, go to FETCH.
  - j: pc_we=1, pc_src=2, retire, go to FETCH.
  - jal: same as j, plus reg_write=1, reg_dst=2, wd_sel=2. Link is the PC register value, which is already PC+4.
  - jr: pc_we=1, pc_src=3, retire, go to FETCH.
  - illegal: set illegal, no writes, no retire, go to FETCH.
  - otherwise: go to EXEC.
- EXEC: alu_src, ext_sign and alu_ctrl are driven per instruction and held through MEM/WB.
  - addu: alu_ctrl 0. subu, beq: alu_ctrl 1. ori, or: alu_ctrl 3. lui: alu_ctrl 4. lw/sw/sb: alu_ctrl 0.
  - ext_sign=1 for lw, sw, sb, beq.
  - beq: pc_we=zero, pc_src=1, retire, go to FETCH.
  - ALU ops: go to WB.
  - lw/sw/sb: go to MEM, except sw or lw with addr_lo!=0, which sets illegal, does not retire, and goes to FETCH without any dmem_req.
- MEM: dmem_req=1, held until mem_ready.
  - byte_en: 1111 for lw/sw; for sb, one-hot at bit addr_lo (e.g. addr_lo=2 gives 0100).
  - mem_write=1 for sw/sb.
  - Store with mem_ready: retire, go to FETCH.
  - lw with mem_ready: go to WB.
- WB: reg_write=1, then retire and go to FETCH.
  - reg_dst=1 for R-type, else 0.
  - wd_sel=1 for lw, else 0.
- Minimum latencies (zero wait states): nop/j/jal/jr 2 cycles, beq 3, ALU 4, store 4, lw 5. Each wait cycle adds exactly 1.
- retire pulses in the final cycle of each legal instruction, and retire_cnt increments on that edge.
- illegal is sticky and clears only on reset.
- Outside its own state, each enable is 0. byte_en=0 whenever dmem_req=0.

Test Plan:
- Reset low mid-MEM with dmem_req=1 -> dmem_req=0 that cycle; after release state is FETCH, retire_cnt=0, illegal=0.
- addu (op 0, func 100001), instr_ready and mem_ready always 1 -> ir_we/pc_we in cycle 1; WB in cycle 4 with reg_write=1, reg_dst=1, alu_ctrl=0; retire_cnt=1.
- lw with mem_ready delayed 3 cycles -> dmem_req held 4 cycles, byte_en=1111, mem_write=0; WB has wd_sel=1; total 8 cycles.
- sb with addr_lo=3 -> byte_en=1000, mem_write=1. The same sb with SUPPORT_SB=0 -> illegal=1, no dmem_req, retire_cnt unchanged.
- beq with zero=1 -> pc_we=1, pc_src=1 in EXEC; with zero=0 -> pc_we=0; both take 3 cycles. jal -> reg_dst=2, wd_sel=2, reg_write=1 in DECODE.
- CNT_W=4, 17 nops -> retire_cnt wraps to 1. sw with addr_lo=2 -> illegal=1, no dmem_req, next FETCH follows immediately.
